// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Subtraction is a + ~b + 1, so cout=1 means no borrow.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic             sum_bit;
    logic             carry_out;
    logic [WIDTH-1:0] a_shift;

    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    // Sum bits enter at the top of the A register, so after WIDTH steps it holds the result.
    generate
        if (WIDTH == 1) begin : g_shift1
            assign a_shift = sum_bit;
        end else begin : g_shiftn
            assign a_shift = {sum_bit, a_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{op_sub}};
                    carry_d = op_sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_shift;
                b_d     = b_q >> 1;
                carry_d = carry_out;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB on this final step
                    state_d  = S_DONE;
                    result_d = a_shift;
                    cout_d   = carry_out;
                    ovf_d    = carry_q ^ carry_out;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH=8 with hand-computed expectations.
module tb_serial_addsub_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       op_sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, cout, ovf;
    logic [7:0] result;

    int n_cmp = 0;
    int n_err = 0;

    serial_addsub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
        .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one operation and observes the 12 cycles after the accepting edge.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sub,
                          input int inj_cyc, input logic [7:0] prev_exp,
                          output logic [7:0] r, output logic co, output logic ov,
                          output int lat, output int bcnt, output int npulse, output int nhold);
        @(negedge clk);
        a = av; b = bv; op_sub = sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hA5; b = 8'h5A; op_sub = ~sub;
        lat = 0; bcnt = 0; npulse = 0; nhold = 0; r = '0; co = 1'b0; ov = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (busy) bcnt++;
            if (done) begin
                npulse++;
                if (lat == 0) begin
                    lat = c; r = result; co = cout; ov = ovf;
                end
            end else if (busy && result !== prev_exp) begin
                nhold++;
            end
            if (c == inj_cyc) begin
                start = 1'b1; a = 8'h55; b = 8'h11;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    logic [7:0] r;
    logic       co, ov;
    int         lat, bcnt, npulse, nhold;
    int         ndone, first_done, second_done, adjacent;
    logic       prev_done;

    initial begin
        // Reset state
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_result", result, 8'h00);
        check_eq("rst_cout_ovf", {cout, ovf}, 2'b00);
        @(negedge clk); rst = 1'b0;

        run_op(8'h3C, 8'h05, 1'b0, 0, 8'h00, r, co, ov, lat, bcnt, npulse, nhold);
        check_eq("add3C05_res", r, 8'h41);
        check_eq("add3C05_cout_ovf", {co, ov}, 2'b00);
        check_eq("add3C05_latency", lat, 9);
        check_eq("add3C05_busy_cycles", bcnt, 9);
        check_eq("add3C05_pulses", npulse, 1);
        check_eq("add3C05_hold", nhold, 0);

        run_op(8'hFF, 8'h01, 1'b0, 0, 8'h41, r, co, ov, lat, bcnt, npulse, nhold);
        check_eq("addFF01_res", r, 8'h00);
        check_eq("addFF01_cout_ovf", {co, ov}, 2'b10);
        check_eq("addFF01_hold", nhold, 0);

        run_op(8'h7F, 8'h01, 1'b0, 0, 8'h00, r, co, ov, lat, bcnt, npulse, nhold);
        check_eq("add7F01_res", r, 8'h80);
        check_eq("add7F01_cout_ovf", {co, ov}, 2'b01);

        run_op(8'h05, 8'h07, 1'b1, 0, 8'h80, r, co, ov, lat, bcnt, npulse, nhold);
        check_eq("sub0507_res", r, 8'hFE);
        check_eq("sub0507_cout_ovf", {co, ov}, 2'b00);
        check_eq("sub0507_latency", lat, 9);

        run_op(8'h80, 8'h01, 1'b1, 0, 8'hFE, r, co, ov, lat, bcnt, npulse, nhold);
        check_eq("sub8001_res", r, 8'h7F);
        check_eq("sub8001_cout_ovf", {co, ov}, 2'b11);

        // Second start during RUN must be ignored
        run_op(8'h10, 8'h20, 1'b0, 3, 8'h7F, r, co, ov, lat, bcnt, npulse, nhold);
        check_eq("ign_res", r, 8'h30);
        check_eq("ign_pulses", npulse, 1);
        check_eq("ign_busy_cycles", bcnt, 9);
        check_eq("ign_idle_after", busy, 0);

        // start held high: accepts every 10 cycles
        @(negedge clk);
        a = 8'h01; b = 8'h02; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        ndone = 0; first_done = 0; second_done = 0; adjacent = 0; prev_done = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) first_done = c;
                if (ndone == 2) second_done = c;
                if (prev_done) adjacent++;
            end
            prev_done = done;
            if (c == 30) start = 1'b0;
            if (c < 30) begin
                @(posedge clk); #1;
            end
        end
        check_eq("b2b_done_count", ndone, 3);
        check_eq("b2b_first_done", first_done, 9);
        check_eq("b2b_period", second_done - first_done, 10);
        check_eq("b2b_pulse_width", adjacent, 0);
        check_eq("b2b_result", result, 8'h03);
        @(posedge clk); #1;
        check_eq("b2b_idle_after", busy, 0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        a = 8'h33; b = 8'h44; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_result", result, 8'h00);
        check_eq("arst_cout_ovf", {cout, ovf}, 2'b00);
        start = 1'b1; a = 8'h99; b = 8'h99;
        @(posedge clk); #1;
        check_eq("arst_start_ignored", busy, 0);
        start = 1'b0;
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check_eq("arst_no_done", ndone, 0);
        check_eq("arst_result_kept", result, 8'h00);

        run_op(8'h01, 8'h01, 1'b0, 0, 8'h00, r, co, ov, lat, bcnt, npulse, nhold);
        check_eq("post_rst_res", r, 8'h02);
        check_eq("post_rst_latency", lat, 9);
        check_eq("post_rst_cout_ovf", {co, ov}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits; legal range 1..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one operation.
REQ-005 The block SHALL have port op_sub, input, 1 bit: operation select, 0 = a+b, 1 = a-b; sampled with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, WIDTH bits: sum or difference.
REQ-010 The block SHALL have port cout, output, 1 bit: final carry; for subtract, 1 = no borrow.
REQ-011 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-012 The block SHALL sequence one 1-bit full-adder step per cycle, LSB first: sum = a^b^c, carry = majority(a,b,c).
REQ-013 The block SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL:
- latch a into the A shift register;
- latch b XOR {WIDTH{op_sub}} into the B shift register;
- set carry = op_sub and bit counter = 0;
- enter RUN.
REQ-015 In RUN, each edge SHALL:
- shift in one sum bit;
- update carry;
- increment the counter.
REQ-016 The block SHALL leave RUN for DONE at the edge processing bit WIDTH-1; RUN lasts exactly WIDTH cycles.
REQ-017 On entry to DONE, the block SHALL load result, cout and ovf in the same edge.
- ovf = carry into MSB XOR carry out of MSB.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: done is high in cycle WIDTH+1 after the accepting edge, independent of operand values.
REQ-020 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored in RUN and DONE.
- No queuing of ignored starts.
- Latched operands are unaffected by input changes after acceptance.
REQ-022 result, cout and ovf SHALL hold their values from DONE until the next DONE entry; they SHALL NOT change during RUN.
REQ-023 The bit counter SHALL be max(1, clog2(WIDTH)) bits wide. For WIDTH=1, RUN lasts one cycle and ovf = carry-in XOR carry-out.
REQ-024 Wrap-around (e.g. 0xFF+0x01) SHALL yield result modulo 2^WIDTH, with the carry reported on cout.

Reset
REQ-025 rst=1 SHALL immediately force, without waiting for a clock edge:
- state to IDLE;
- busy=0, done=0, result=0, cout=0, ovf=0;
- the counter, carry and shift registers to 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation, with no done pulse and no result update.
REQ-027 While rst=1, start SHALL be ignored. The first start is accepted at the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-028 add 0x3C+0x05 -> result=0x41, cout=0, ovf=0; done exactly 9 cycles after the accepting edge; busy high 9 cycles.
REQ-029 add 0xFF+0x01 -> result=0x00, cout=1, ovf=0; add 0x7F+0x01 -> result=0x80, cout=0, ovf=1.
REQ-030 sub 0x05-0x07 -> result=0xFE, cout=0 (borrow), ovf=0; sub 0x80-0x01 -> result=0x7F, cout=1, ovf=1.
REQ-031 Second start with different operands pulsed at cycle 3 of RUN:
- the second start is ignored;
- the first result is unchanged;
- exactly one done pulse occurs.
REQ-032 Back-to-back start held high continuously -> operations accepted every 10 cycles, each done 1 cycle wide.
REQ-033 rst pulsed during cycle 4 of RUN (mid-cycle, asynchronous):
- outputs are 0 immediately;
- no done pulse follows;
- a subsequent add 0x01+0x01 -> 0x02.
